// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: decodes IF/ID, forwards operands from EX/MEM,
// stalls on load-use and drives a valid/ready ID/EX register with flush.
module id_stage_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALU_LEN    = 5,
    parameter int unsigned JUMP_LEN   = 2,
    parameter int unsigned BRANCH_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_pc,
    input  logic [31:0]           in_inst,
    output logic [REG_ADDR_W-1:0] reg1_addr_o,
    output logic [REG_ADDR_W-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]       reg1_data_i,
    input  logic [XLEN-1:0]       reg2_data_i,
    input  logic                  ex_wr_valid,
    input  logic [REG_ADDR_W-1:0] ex_wr_rd,
    input  logic [XLEN-1:0]       ex_wr_data,
    input  logic                  ex_is_load,
    input  logic                  mem_wr_valid,
    input  logic [REG_ADDR_W-1:0] mem_wr_rd,
    input  logic [XLEN-1:0]       mem_wr_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_pc,
    output logic [XLEN-1:0]       out_reg1,
    output logic [XLEN-1:0]       out_reg2,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_enable,
    output logic [ALU_LEN-1:0]    out_alu_op,
    output logic [JUMP_LEN-1:0]   out_jump_op,
    output logic [BRANCH_LEN-1:0] out_branch_op,
    output logic                  out_illegal
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [ALU_LEN-1:0] AluNone   = ALU_LEN'(0);
    localparam logic [ALU_LEN-1:0] AluAdd    = ALU_LEN'(1);
    localparam logic [ALU_LEN-1:0] AluSub    = ALU_LEN'(2);
    localparam logic [ALU_LEN-1:0] AluSll    = ALU_LEN'(3);
    localparam logic [ALU_LEN-1:0] AluSlt    = ALU_LEN'(4);
    localparam logic [ALU_LEN-1:0] AluSltu   = ALU_LEN'(5);
    localparam logic [ALU_LEN-1:0] AluXor    = ALU_LEN'(6);
    localparam logic [ALU_LEN-1:0] AluSrl    = ALU_LEN'(7);
    localparam logic [ALU_LEN-1:0] AluSra    = ALU_LEN'(8);
    localparam logic [ALU_LEN-1:0] AluOr     = ALU_LEN'(9);
    localparam logic [ALU_LEN-1:0] AluAnd    = ALU_LEN'(10);
    localparam logic [ALU_LEN-1:0] AluAddi   = ALU_LEN'(11);
    localparam logic [ALU_LEN-1:0] AluSlli   = ALU_LEN'(12);
    localparam logic [ALU_LEN-1:0] AluSlti   = ALU_LEN'(13);
    localparam logic [ALU_LEN-1:0] AluSltiu  = ALU_LEN'(14);
    localparam logic [ALU_LEN-1:0] AluXori   = ALU_LEN'(15);
    localparam logic [ALU_LEN-1:0] AluSrli   = ALU_LEN'(16);
    localparam logic [ALU_LEN-1:0] AluSrai   = ALU_LEN'(17);
    localparam logic [ALU_LEN-1:0] AluOri    = ALU_LEN'(18);
    localparam logic [ALU_LEN-1:0] AluAndi   = ALU_LEN'(19);
    localparam logic [ALU_LEN-1:0] AluLui    = ALU_LEN'(20);
    localparam logic [ALU_LEN-1:0] AluAuipc  = ALU_LEN'(21);
    localparam logic [ALU_LEN-1:0] AluJal    = ALU_LEN'(22);
    localparam logic [ALU_LEN-1:0] AluJalr   = ALU_LEN'(23);
    localparam logic [ALU_LEN-1:0] AluBranch = ALU_LEN'(24);
    localparam logic [ALU_LEN-1:0] AluLoad   = ALU_LEN'(25);
    localparam logic [ALU_LEN-1:0] AluStore  = ALU_LEN'(26);

    typedef struct packed {
        logic [ADDR_W-1:0]     pc;
        logic [XLEN-1:0]       reg1;
        logic [XLEN-1:0]       reg2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_enable;
        logic [ALU_LEN-1:0]    alu_op;
        logic [JUMP_LEN-1:0]   jump_op;
        logic [BRANCH_LEN-1:0] branch_op;
        logic                  illegal;
    } idex_t;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic                  use_rs1, use_rs2, writes_rd, illegal;
    logic [ALU_LEN-1:0]    alu_op;
    logic [JUMP_LEN-1:0]   jump_op;
    logic [BRANCH_LEN-1:0] branch_op;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       dec_imm, rs1_val, rs2_val;
    logic                  load_use;
    logic                  valid_q, valid_d;
    idex_t                 idex_q, idex_d;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};

    always_comb begin
        imm32     = 32'h0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        alu_op    = AluNone;
        jump_op   = '0;
        branch_op = '0;
        case (opcode)
            OpLui:   begin imm32 = imm_u; writes_rd = 1'b1; alu_op = AluLui;   end
            OpAuipc: begin imm32 = imm_u; writes_rd = 1'b1; alu_op = AluAuipc; end
            OpJal: begin
                imm32 = imm_j; writes_rd = 1'b1; alu_op = AluJal; jump_op = JUMP_LEN'(1);
            end
            OpJalr: begin
                imm32 = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
                alu_op = AluJalr; jump_op = JUMP_LEN'(2);
                illegal = (funct3 != 3'd0);
            end
            OpBranch: begin
                imm32 = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; alu_op = AluBranch;
                case (funct3)
                    3'd0:    branch_op = BRANCH_LEN'(1);
                    3'd1:    branch_op = BRANCH_LEN'(2);
                    3'd4:    branch_op = BRANCH_LEN'(3);
                    3'd5:    branch_op = BRANCH_LEN'(4);
                    3'd6:    branch_op = BRANCH_LEN'(5);
                    3'd7:    branch_op = BRANCH_LEN'(6);
                    default: illegal = 1'b1;
                endcase
            end
            OpLoad: begin
                imm32 = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1; alu_op = AluLoad;
                illegal = (funct3 == 3'd3) || (funct3 > 3'd5);
            end
            OpStore: begin
                imm32 = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; alu_op = AluStore;
                illegal = (funct3 > 3'd2);
            end
            OpImm: begin
                imm32 = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
                case (funct3)
                    3'd0: alu_op = AluAddi;
                    3'd1: begin alu_op = AluSlli; illegal = (funct7 != 7'h00); end
                    3'd2: alu_op = AluSlti;
                    3'd3: alu_op = AluSltiu;
                    3'd4: alu_op = AluXori;
                    3'd5: begin
                        alu_op  = funct7[5] ? AluSrai : AluSrli;
                        illegal = !(funct7 inside {7'h00, 7'h20});
                    end
                    3'd6:    alu_op = AluOri;
                    default: alu_op = AluAndi;
                endcase
            end
            OpReg: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
                case (funct3)
                    3'd0:    alu_op = funct7[5] ? AluSub : AluAdd;
                    3'd1:    alu_op = AluSll;
                    3'd2:    alu_op = AluSlt;
                    3'd3:    alu_op = AluSltu;
                    3'd4:    alu_op = AluXor;
                    3'd5:    alu_op = funct7[5] ? AluSra : AluSrl;
                    3'd6:    alu_op = AluOr;
                    default: alu_op = AluAnd;
                endcase
                // funct7=0x20 only selects SUB/SRA; anything else non-zero is undecodable
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && (funct3 inside {3'd0, 3'd5})));
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_op    = AluNone;
            jump_op   = '0;
            branch_op = '0;
        end
    end

    assign reg1_addr_o = use_rs1 ? REG_ADDR_W'(in_inst[19:15]) : '0;
    assign reg2_addr_o = use_rs2 ? REG_ADDR_W'(in_inst[24:20]) : '0;
    assign rd_addr     = writes_rd ? REG_ADDR_W'(in_inst[11:7]) : '0;
    assign dec_imm     = XLEN'($signed(imm32));

    function automatic logic [XLEN-1:0] fwd_operand(input logic [REG_ADDR_W-1:0] addr,
                                                    input logic [XLEN-1:0]       rf_data);
        if (addr == '0) return '0;
        if (ex_wr_valid && !ex_is_load && (ex_wr_rd == addr)) return ex_wr_data;
        if (mem_wr_valid && (mem_wr_rd == addr)) return mem_wr_data;
        return rf_data;
    endfunction

    assign rs1_val = fwd_operand(reg1_addr_o, reg1_data_i);
    assign rs2_val = fwd_operand(reg2_addr_o, reg2_data_i);

    // Unused sources read as address 0, so they never match a non-zero load target
    assign load_use = in_valid && ex_wr_valid && ex_is_load && (ex_wr_rd != '0) &&
                      ((ex_wr_rd == reg1_addr_o) || (ex_wr_rd == reg2_addr_o));
    assign in_ready = (!valid_q || out_ready) && !load_use && !flush;

    always_comb begin
        valid_d = valid_q;
        idex_d  = idex_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d          = 1'b1;
            idex_d.pc        = in_pc;
            idex_d.reg1      = rs1_val;
            idex_d.reg2      = use_rs2 ? rs2_val : dec_imm;
            idex_d.imm       = dec_imm;
            idex_d.rd        = rd_addr;
            idex_d.rd_enable = writes_rd && (rd_addr != '0) && !illegal;
            idex_d.alu_op    = alu_op;
            idex_d.jump_op   = jump_op;
            idex_d.branch_op = branch_op;
            idex_d.illegal   = illegal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            idex_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idex_q  <= idex_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = idex_q.pc;
    assign out_reg1      = idex_q.reg1;
    assign out_reg2      = idex_q.reg2;
    assign out_imm       = idex_q.imm;
    assign out_rd        = idex_q.rd;
    assign out_rd_enable = idex_q.rd_enable;
    assign out_alu_op    = idex_q.alu_op;
    assign out_jump_op   = idex_q.jump_op;
    assign out_branch_op = idex_q.branch_op;
    assign out_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed vector table, hand-written stall/flush/reset
// sequences, then random traffic against a behavioural decode/handshake model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, ex_wr_valid, ex_is_load, mem_wr_valid, flush;
    logic        out_valid, out_ready, out_rd_enable, out_illegal;
    logic [31:0] in_pc, in_inst, reg1_data_i, reg2_data_i, ex_wr_data, mem_wr_data;
    logic [31:0] out_pc, out_reg1, out_reg2, out_imm;
    logic [4:0]  reg1_addr_o, reg2_addr_o, ex_wr_rd, mem_wr_rd, out_rd, out_alu_op;
    logic [1:0]  out_jump_op;
    logic [2:0]  out_branch_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_wr_valid(ex_wr_valid),
        .ex_wr_rd(ex_wr_rd), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
        .mem_wr_valid(mem_wr_valid), .mem_wr_rd(mem_wr_rd), .mem_wr_data(mem_wr_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm), .out_rd(out_rd),
        .out_rd_enable(out_rd_enable), .out_alu_op(out_alu_op), .out_jump_op(out_jump_op),
        .out_branch_op(out_branch_op), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] pc, reg1, reg2, imm;
        logic [4:0]  rd, rs1, rs2, alu;
        logic        rde, ill;
        logic [1:0]  jump;
        logic [2:0]  br;
    } dec_t;

    typedef struct {
        logic [31:0] inst, rf1, rf2;
        logic        ex_v, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_d;
        logic        mem_v;
        logic [4:0]  mem_rd;
        logic [31:0] mem_d;
        logic [31:0] e_imm, e_r1, e_r2;
        logic [4:0]  e_rd;
        logic        e_rde;
        logic [4:0]  e_alu;
        logic [1:0]  e_j;
        logic [2:0]  e_br;
        logic        e_ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (ex_wr_valid && !ex_is_load && ex_wr_rd == a) return ex_wr_data;
        if (mem_wr_valid && mem_wr_rd == a) return mem_wr_data;
        return rf;
    endfunction

    // Decode straight from the ISA tables; ALU codes follow funct3 order per group
    function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] rf1, input logic [31:0] rf2);
        dec_t d;
        int   f3, f7, a;
        logic has1, has2, hasrd, ill;
        d  = '{default: '0};
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        has1 = 0; has2 = 0; hasrd = 0; ill = 0; a = 0;
        case (i[6:0])
            7'h37: begin d.imm = {i[31:12], 12'b0}; hasrd = 1; a = 20; end
            7'h17: begin d.imm = {i[31:12], 12'b0}; hasrd = 1; a = 21; end
            7'h6F: begin
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                hasrd = 1; a = 22; d.jump = 2'd1;
            end
            7'h67: begin
                d.imm = {{20{i[31]}}, i[31:20]}; has1 = 1; hasrd = 1; a = 23; d.jump = 2'd2;
                ill = (f3 != 0);
            end
            7'h63: begin
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                has1 = 1; has2 = 1; a = 24;
                ill = (f3 == 2 || f3 == 3);
                d.br = 3'((f3 < 2) ? f3 + 1 : f3 - 1);
            end
            7'h03: begin
                d.imm = {{20{i[31]}}, i[31:20]}; has1 = 1; hasrd = 1; a = 25;
                ill = (f3 == 3 || f3 >= 6);
            end
            7'h23: begin
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; has1 = 1; has2 = 1; a = 26;
                ill = (f3 > 2);
            end
            7'h13: begin
                d.imm = {{20{i[31]}}, i[31:20]}; has1 = 1; hasrd = 1;
                a = 11 + f3 + ((f3 >= 6) ? 1 : 0) + ((f3 == 5 && f7 == 32) ? 1 : 0);
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) ill = (f7 != 0 && f7 != 32);
            end
            7'h33: begin
                has1 = 1; has2 = 1; hasrd = 1;
                if (f3 == 0) a = (f7 == 32) ? 2 : 1;
                else a = f3 + 2 + ((f3 >= 6) ? 1 : 0) + ((f3 == 5 && f7 == 32) ? 1 : 0);
                ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            end
            default: ill = 1;
        endcase
        d.pc  = pc;
        d.rs1 = has1 ? i[19:15] : 5'd0;
        d.rs2 = has2 ? i[24:20] : 5'd0;
        d.rd  = hasrd ? i[11:7] : 5'd0;
        d.rde = hasrd && d.rd != 0 && !ill;
        d.ill = ill;
        d.alu = ill ? 5'd0 : 5'(a);
        if (ill) begin d.jump = 2'd0; d.br = 3'd0; end
        d.reg1 = ref_fwd(d.rs1, rf1);
        d.reg2 = has2 ? ref_fwd(d.rs2, rf2) : d.imm;
        return d;
    endfunction

    task automatic chk_out(input string t, input logic ev, input dec_t e);
        chk({t, ".valid"}, 32'(out_valid), 32'(ev));
        chk({t, ".pc"}, out_pc, e.pc);
        chk({t, ".reg1"}, out_reg1, e.reg1);
        chk({t, ".reg2"}, out_reg2, e.reg2);
        chk({t, ".imm"}, out_imm, e.imm);
        chk({t, ".rd"}, 32'(out_rd), 32'(e.rd));
        chk({t, ".rde"}, 32'(out_rd_enable), 32'(e.rde));
        chk({t, ".alu"}, 32'(out_alu_op), 32'(e.alu));
        chk({t, ".jump"}, 32'(out_jump_op), 32'(e.jump));
        chk({t, ".br"}, 32'(out_branch_op), 32'(e.br));
        chk({t, ".ill"}, 32'(out_illegal), 32'(e.ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[11];
    logic [6:0]  ops[10];
    dec_t        m_out, zero_d, cur;
    logic        m_valid, hz, exp_rdy;

    initial begin
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        // inst rf1 rf2 | ex v,ld,rd,d | mem v,rd,d | imm r1 r2 rd rde alu j br ill
        vecs[0]  = '{32'hFFF00093, 32'h9, 32'h9, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 5'd1, 1, 5'd11, 2'd0, 3'd0, 0};
        vecs[1]  = '{32'hFE208EE3, 32'h5, 32'h5, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'hFFFFFFFC, 32'h5, 32'h5, 5'd0, 0, 5'd24, 2'd0, 3'd1, 0};
        vecs[2]  = '{32'h002081B3, 32'h44, 32'h77, 1, 0, 5'd1, 32'h11, 1, 5'd1, 32'h22,
                     32'h0, 32'h11, 32'h77, 5'd3, 1, 5'd1, 2'd0, 3'd0, 0};
        vecs[3]  = '{32'h002081B3, 32'h44, 32'h77, 1, 0, 5'd1, 32'h11, 1, 5'd2, 32'h33,
                     32'h0, 32'h11, 32'h33, 5'd3, 1, 5'd1, 2'd0, 3'd0, 0};
        vecs[4]  = '{32'h002081B3, 32'h44, 32'h77, 1, 0, 5'd0, 32'h11, 0, 5'd0, 32'h0,
                     32'h0, 32'h44, 32'h77, 5'd3, 1, 5'd1, 2'd0, 3'd0, 0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h1, 32'h2, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h0, 32'h0, 32'h0, 5'd0, 0, 5'd0, 2'd0, 3'd0, 1};
        vecs[6]  = '{32'h022081B3, 32'hA, 32'hB, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h0, 32'hA, 32'hB, 5'd3, 0, 5'd0, 2'd0, 3'd0, 1};
        vecs[7]  = '{32'h123452B7, 32'h1, 32'h2, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h12345000, 32'h0, 32'h12345000, 5'd5, 1, 5'd20, 2'd0, 3'd0, 0};
        vecs[8]  = '{32'h008000EF, 32'h1, 32'h2, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h8, 32'h0, 32'h8, 5'd1, 1, 5'd22, 2'd1, 3'd0, 0};
        vecs[9]  = '{32'h0020A623, 32'hC1, 32'hC2, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'hC, 32'hC1, 32'hC2, 5'd0, 0, 5'd26, 2'd0, 3'd0, 0};
        vecs[10] = '{32'h4030D213, 32'hD1, 32'hD2, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                     32'h403, 32'hD1, 32'h403, 5'd4, 1, 5'd17, 2'd0, 3'd0, 0};

        rst = 1'b1; in_valid = 0; in_pc = 0; in_inst = 0; reg1_data_i = 0; reg2_data_i = 0;
        ex_wr_valid = 0; ex_wr_rd = 0; ex_wr_data = 0; ex_is_load = 0; mem_wr_valid = 0;
        mem_wr_rd = 0; mem_wr_data = 0; flush = 0; out_ready = 1;
        zero_d = '{default: '0};
        tick();
        chk_out("reset", 1'b0, zero_d);
        #1 rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            in_valid = 1; in_pc = 32'h1000 + 32'(4 * k); in_inst = vecs[k].inst;
            reg1_data_i = vecs[k].rf1; reg2_data_i = vecs[k].rf2;
            ex_wr_valid = vecs[k].ex_v; ex_is_load = vecs[k].ex_ld;
            ex_wr_rd = vecs[k].ex_rd; ex_wr_data = vecs[k].ex_d;
            mem_wr_valid = vecs[k].mem_v; mem_wr_rd = vecs[k].mem_rd;
            mem_wr_data = vecs[k].mem_d;
            #1 chk($sformatf("vec%0d.in_ready", k), 32'(in_ready), 32'd1);
            tick();
            cur = '{pc: in_pc, reg1: vecs[k].e_r1, reg2: vecs[k].e_r2, imm: vecs[k].e_imm,
                    rd: vecs[k].e_rd, rs1: 5'd0, rs2: 5'd0, alu: vecs[k].e_alu,
                    rde: vecs[k].e_rde, ill: vecs[k].e_ill, jump: vecs[k].e_j,
                    br: vecs[k].e_br};
            chk_out($sformatf("vec%0d", k), 1'b1, cur);
        end

        // Load-use: lw x1 in EX, add x3,x1,x2 waiting in IF/ID
        in_inst = 32'h002081B3; in_pc = 32'h2000; reg1_data_i = 32'h5555;
        reg2_data_i = 32'h6666; mem_wr_valid = 0;
        ex_wr_valid = 1; ex_is_load = 1; ex_wr_rd = 5'd1; ex_wr_data = 32'hBAD;
        #1 chk("lu.stall_ready", 32'(in_ready), 32'd0);
        tick();
        chk("lu.bubble", 32'(out_valid), 32'd0);
        ex_wr_valid = 0; ex_is_load = 0;
        mem_wr_valid = 1; mem_wr_rd = 5'd1; mem_wr_data = 32'hDEAD;
        #1 chk("lu.resume_ready", 32'(in_ready), 32'd1);
        tick();
        chk("lu.valid", 32'(out_valid), 32'd1);
        chk("lu.reg1_mem", out_reg1, 32'hDEAD);
        chk("lu.reg2", out_reg2, 32'h6666);

        // Backpressure holds everything, then flush drops the held instruction
        out_ready = 0; mem_wr_valid = 0; in_inst = 32'hFFF00093; in_pc = 32'h2004;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp.in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.reg1", out_reg1, 32'hDEAD);
            chk("bp.pc", out_pc, 32'h2000);
            chk("bp.rd", 32'(out_rd), 32'd3);
        end
        flush = 1;
        #1 chk("fl.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fl.valid", 32'(out_valid), 32'd0);

        // Flush with in_valid and empty output register still drops the instruction
        out_ready = 1;
        tick();
        chk("fl2.valid", 32'(out_valid), 32'd0);
        flush = 0;
        tick();
        chk("acc.valid", 32'(out_valid), 32'd1);
        chk("acc.imm", out_imm, 32'hFFFFFFFF);

        // Asynchronous reset while stalled, checked before any clock edge
        out_ready = 0;
        #2 rst = 1;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.imm", out_imm, 32'd0);
        chk("arst.rd", 32'(out_rd), 32'd0);
        #2 rst = 0;

        m_valid = 0;
        m_out   = zero_d;
        for (int n = 0; n < 600; n++) begin
            in_inst = $urandom();
            in_inst[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) != 0) begin
                in_inst[19:15] = 5'($urandom_range(0, 3));
                in_inst[24:20] = 5'($urandom_range(0, 3));
                in_inst[11:7]  = 5'($urandom_range(0, 3));
            end
            case ($urandom_range(0, 3))
                0: in_inst[31:25] = 7'h00;
                1: in_inst[31:25] = 7'h20;
                default: ;
            endcase
            in_pc        = $urandom();
            in_valid     = ($urandom_range(0, 4) != 0);
            out_ready    = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 9) == 0);
            reg1_data_i  = $urandom();
            reg2_data_i  = $urandom();
            ex_wr_valid  = ($urandom_range(0, 1) == 1);
            ex_is_load   = ($urandom_range(0, 2) == 0);
            ex_wr_rd     = 5'($urandom_range(0, 3));
            ex_wr_data   = $urandom();
            mem_wr_valid = ($urandom_range(0, 1) == 1);
            mem_wr_rd    = 5'($urandom_range(0, 3));
            mem_wr_data  = $urandom();
            #1;
            cur = ref_dec(in_inst, in_pc, reg1_data_i, reg2_data_i);
            hz = in_valid && ex_wr_valid && ex_is_load && ex_wr_rd != 0 &&
                 (ex_wr_rd == cur.rs1 || ex_wr_rd == cur.rs2);
            exp_rdy = (!m_valid || out_ready) && !hz && !flush;
            chk("rnd.in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rnd.rs1", 32'(reg1_addr_o), 32'(cur.rs1));
            chk("rnd.rs2", 32'(reg2_addr_o), 32'(cur.rs2));
            @(posedge clk);
            if (flush) m_valid = 0;
            else if (in_valid && exp_rdy) begin m_valid = 1; m_out = cur; end
            else if (out_ready) m_valid = 0;
            #1 chk_out("rnd", m_valid, m_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
